subword_store_unit: RTL and testbench
=====================================

// Module: subword_store_unit
// PURPOSE
//  Store-side counterpart of the datapath's immediate/load sign-extension path: narrows a 32-bit
//  register value to byte/halfword/word and writes it into word-organised data memory.
//  Sub-word stores (SB/SH) use a read-modify-write sequence; SW writes directly.
//  Sits between the multicycle control FSM and the data memory port.
// PARAMETERS
//  WIDTH       32  data word width (fixed at 32; lanes are 8 bits)
//  ADDR_WIDTH  32  byte-address width
// PORTS
//  clk           in   1           single clock, rising edge
//  reset         in   1           one clock; reset is asynchronous and active-low
//  start         in   1           request pulse, sampled only in IDLE
//  size          in   2           00=byte, 01=half, 10=word, 11=illegal
//  addr          in   ADDR_WIDTH  byte address of store
//  wdata         in   WIDTH       register value; low 8/16/32 bits are stored
//  busy          out  1           high from cycle after accepted start until DONE/ERR exits
//  done          out  1           one-cycle pulse at completion (also on error)
//  misalign_err  out  1           one-cycle pulse with done; no memory access made
//  mem_addr      out  ADDR_WIDTH  word-aligned: {addr[ADDR_WIDTH-1:2],2'b00}
//  mem_rd        out  1           read request, held until mem_ready
//  mem_wr        out  1           write request, held until mem_ready
//  mem_wdata     out  WIDTH       merged write word
//  mem_rdata     in   WIDTH       read data, valid when mem_ready && mem_rd
//  mem_ready     in   1           memory handshake; completes current rd/wr this cycle
// BEHAVIOUR
//  - All outputs registered. On reset=0 (async): state=IDLE, every output 0; internal regs 0.
//  - States: IDLE, READ, MERGE, WRITE, DONE, ERR.
//  - IDLE: on start=1 latch addr,size,wdata. Then:
//      size=11, or size=01 && addr[0]!=0, or size=10 && addr[1:0]!=0 -> ERR
//      size=10 -> WRITE (mem_wdata=wdata); else -> READ
//  - start while not IDLE is ignored (not queued).
//  - READ: mem_rd=1, mem_addr valid; stay until mem_ready=1, capture mem_rdata -> MERGE.
//  - MERGE (1 cycle): little-endian lanes, lane k = bits 8k+7:8k, k=addr[1:0].
//      byte: lane k <= wdata[7:0]; half: lanes k,k+1 <= wdata[15:0] (k=0 or 2);
//      other lanes keep captured read word -> WRITE.
//  - WRITE: mem_wr=1, mem_wdata stable; stay until mem_ready=1 -> DONE.
//  - mem_rd and mem_wr are never high in the same cycle.
//  - DONE: done=1 one cycle -> IDLE. ERR: done=1, misalign_err=1 one cycle -> IDLE.
//  - Latency (start at edge T, mem_ready tied 1): SW done at T+2; SB/SH done at T+4;
//    each mem_ready=0 cycle adds one. Error done at T+1.
//  - Back-to-back: start may be asserted in the cycle after done (FSM already IDLE).
//  - Reset mid-operation: request abandoned, mem_wr drops immediately; a write not yet
//    acknowledged is not retried. No partial state survives reset.
//  - Upper wdata bits beyond the stored size are ignored (no overflow check).
// TESTING
//  1 SW: addr=0x10, wdata=0xDEADBEEF, mem_ready=1 -> mem_wr at T+1, mem_wdata=0xDEADBEEF,
//    mem_addr=0x10, done at T+2, no mem_rd.
//  2 SB all lanes: mem word=0x11223344, wdata=0xFFFFFFAB, addr=0x21/0x22/0x23/0x20 ->
//    writes 0x1122AB44, 0x11AB3344, 0xAB223344, 0x112233AB to mem_addr=0x20.
//  3 SH: mem word=0x11223344, wdata=0x0000BEEF, addr=0x32 -> write 0xBEEF3344 at 0x30;
//    addr=0x30 -> 0x1122BEEF.
//  4 Errors: SH addr=0x41, SW addr=0x42, size=11 -> done+misalign_err at T+1, mem_rd=mem_wr=0.
//  5 Wait states: SB with mem_ready low 3 cycles in READ and 2 in WRITE -> mem_rd/mem_wr held
//    stable, done at T+9; start pulsed during busy is ignored.
//  6 Reset: assert reset=0 during WRITE of SB -> outputs 0 asynchronously, state IDLE, next
//    start after release behaves as fresh request.

Source files
------------

// File: rtl/subword_store_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : subword_store_unit_if
// Brief    : Request/response and data-memory port bundle for subword_store_unit.
// Revision : 1.0
// ============================================================================
interface subword_store_unit_if #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  start;
    logic [1:0]            size;
    logic [ADDR_WIDTH-1:0] addr;
    logic [WIDTH-1:0]      wdata;
    logic                  busy;
    logic                  done;
    logic                  misalign_err;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_rd;
    logic                  mem_wr;
    logic [WIDTH-1:0]      mem_wdata;
    logic [WIDTH-1:0]      mem_rdata;
    logic                  mem_ready;

    modport slave (
        input  start, size, addr, wdata, mem_rdata, mem_ready,
        output busy, done, misalign_err, mem_addr, mem_rd, mem_wr, mem_wdata
    );

    modport master (
        output start, size, addr, wdata, mem_rdata, mem_ready,
        input  busy, done, misalign_err, mem_addr, mem_rd, mem_wr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/subword_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : subword_store_unit
// Brief    : Byte/half/word store into word-organised memory; SB/SH via read-modify-write.
// Revision : 1.0
// ============================================================================
module subword_store_unit #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    subword_store_unit_if.slave  bus
);
    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_READ  = 3'd1;
    localparam logic [2:0] c_MERGE = 3'd2;
    localparam logic [2:0] c_WRITE = 3'd3;
    localparam logic [2:0] c_DONE  = 3'd4;
    localparam logic [2:0] c_ERR   = 3'd5;

    logic [2:0]       r_state;
    logic [2:0]       w_state_next;
    logic [1:0]       r_lane;
    logic             r_half;
    logic [15:0]      r_wdata;
    logic [WIDTH-1:0] r_rdata;
    logic [WIDTH-1:0] w_merged;
    logic             w_accept;
    logic             w_misalign;

    assign w_accept = (r_state == c_IDLE) && bus.start;

    always_comb begin
        w_misalign = 1'b0;
        case (bus.size)
            2'b01:   w_misalign = bus.addr[0];
            2'b10:   w_misalign = (bus.addr[1:0] != 2'b00);
            2'b11:   w_misalign = 1'b1;
            default: w_misalign = 1'b0;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (bus.start) begin
                    if (w_misalign)
                        w_state_next = c_ERR;
                    else if (bus.size == 2'b10)
                        w_state_next = c_WRITE;
                    else
                        w_state_next = c_READ;
                end
            end
            c_READ:  if (bus.mem_ready) w_state_next = c_MERGE;
            c_MERGE: w_state_next = c_WRITE;
            c_WRITE: if (bus.mem_ready) w_state_next = c_DONE;
            c_DONE:  w_state_next = c_IDLE;
            c_ERR:   w_state_next = c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
    end

    // Little-endian lane insert; lanes not covered keep the word read back from memory.
    always_comb begin
        w_merged = r_rdata;
        if (r_half) begin
            if (r_lane[1])
                w_merged[31:16] = r_wdata;
            else
                w_merged[15:0]  = r_wdata;
        end else begin
            case (r_lane)
                2'd0:    w_merged[7:0]   = r_wdata[7:0];
                2'd1:    w_merged[15:8]  = r_wdata[7:0];
                2'd2:    w_merged[23:16] = r_wdata[7:0];
                default: w_merged[31:24] = r_wdata[7:0];
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state          <= c_IDLE;
            r_lane           <= 2'd0;
            r_half           <= 1'b0;
            r_wdata          <= 16'd0;
            r_rdata          <= '0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
            bus.misalign_err <= 1'b0;
            bus.mem_addr     <= '0;
            bus.mem_rd       <= 1'b0;
            bus.mem_wr       <= 1'b0;
            bus.mem_wdata    <= '0;
        end else begin
            r_state          <= w_state_next;
            bus.busy         <= (w_state_next != c_IDLE);
            bus.done         <= (w_state_next == c_DONE) || (w_state_next == c_ERR);
            bus.misalign_err <= (w_state_next == c_ERR);
            bus.mem_rd       <= (w_state_next == c_READ);
            bus.mem_wr       <= (w_state_next == c_WRITE);
            if (w_accept) begin
                r_lane       <= bus.addr[1:0];
                r_half       <= bus.size[0];
                r_wdata      <= bus.wdata[15:0];
                bus.mem_addr <= {bus.addr[ADDR_WIDTH-1:2], 2'b00};
                if (bus.size == 2'b10)
                    bus.mem_wdata <= bus.wdata;
            end
            if ((r_state == c_READ) && bus.mem_ready)
                r_rdata <= bus.mem_rdata;
            if (r_state == c_MERGE)
                bus.mem_wdata <= w_merged;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_subword_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_subword_store_unit
// Brief    : Self-checking bench for subword_store_unit against a byte-mask store model.
// Revision : 1.0
// ============================================================================
module tb_subword_store_unit;
    logic clk;
    logic reset;
    int   tests;
    int   fails;

    subword_store_unit_if #(.WIDTH(32), .ADDR_WIDTH(32)) bus ();

    subword_store_unit #(.WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic model_err(input logic [1:0] sz, input logic [31:0] ad);
        return (sz == 2'd3) || (sz == 2'd1 && ad[0]) || (sz == 2'd2 && ad[1:0] != 2'd0);
    endfunction

    function automatic logic [31:0] model_word(input logic [1:0] sz, input logic [31:0] ad,
                                              input logic [31:0] wd, input logic [31:0] old);
        logic [31:0] mask;
        int          sh;
        if (sz == 2'd2) return wd;
        mask = (sz == 2'd0) ? 32'h0000_00FF : 32'h0000_FFFF;
        sh   = 8 * int'(ad[1:0]);
        return (old & ~(mask << sh)) | ((wd & mask) << sh);
    endfunction

    function automatic int model_lat(input logic [1:0] sz, input logic [31:0] ad, input int rdw, input int wrw);
        if (model_err(sz, ad)) return 1;
        if (sz == 2'd2) return 2 + wrw;
        return 4 + rdw + wrw;
    endfunction

    // Drives one request and plays the memory; all observations are returned for checking.
    task automatic do_op(input logic [1:0] sz, input logic [31:0] ad, input logic [31:0] wd,
                         input logic [31:0] mw, input int rdw, input int wrw, input logic poke,
                         output int lat, output logic err, output logic [31:0] waddr,
                         output logic [31:0] wdat, output int nrd, output int nwr,
                         output logic overlap, output logic busy_at_start, output logic busy_gap);
        int rc;
        int wc;
        @(negedge clk);
        busy_at_start = bus.busy;
        bus.start = 1'b1; bus.size = sz; bus.addr = ad; bus.wdata = wd;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        bus.size = 2'($urandom); bus.addr = $urandom; bus.wdata = $urandom;
        lat = 0; err = 1'b0; waddr = '0; wdat = '0; nrd = 0; nwr = 0;
        overlap = 1'b0; busy_gap = 1'b0; rc = 0; wc = 0;
        for (int n = 1; n <= 100; n++) begin
            bus.start     = poke && (n == 2);
            bus.mem_ready = 1'b0;
            bus.mem_rdata = $urandom;
            if (bus.mem_rd && bus.mem_wr) overlap = 1'b1;
            if (!bus.busy) busy_gap = 1'b1;
            if (bus.mem_rd) begin
                nrd++;
                if (rc == rdw) begin bus.mem_ready = 1'b1; bus.mem_rdata = mw; end
                else rc++;
            end
            if (bus.mem_wr) begin
                nwr++;
                if (wc == wrw) begin bus.mem_ready = 1'b1; waddr = bus.mem_addr; wdat = bus.mem_wdata; end
                else wc++;
            end
            if (bus.done) begin
                lat = n; err = bus.misalign_err;
                break;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        bus.mem_ready = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        bus.start = 1'b0; bus.size = 2'd0; bus.addr = '0; bus.wdata = '0;
        bus.mem_rdata = '0; bus.mem_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({bus.busy, bus.done, bus.misalign_err, bus.mem_rd, bus.mem_wr, bus.mem_addr, bus.mem_wdata} !== 69'd0) begin
            fails++;
            $display("FAIL reset_outputs: got busy=%b done=%b err=%b rd=%b wr=%b addr=%h wdata=%h want all 0",
                     bus.busy, bus.done, bus.misalign_err, bus.mem_rd, bus.mem_wr, bus.mem_addr, bus.mem_wdata);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_sw;
        int lat, nrd, nwr; logic err, ov, bs, bg; logic [31:0] wa, wd;
        do_op(2'd2, 32'h10, 32'hDEADBEEF, 32'h0, 0, 0, 1'b0, lat, err, wa, wd, nrd, nwr, ov, bs, bg);
        tests++; if (lat !== 2) begin fails++; $display("FAIL sw_latency: got %0d want 2", lat); end
        tests++; if (wd !== 32'hDEADBEEF) begin fails++; $display("FAIL sw_wdata: got %h want deadbeef", wd); end
        tests++; if (wa !== 32'h10) begin fails++; $display("FAIL sw_addr: got %h want 10", wa); end
        tests++; if (nrd !== 0 || nwr !== 1 || err !== 1'b0) begin
            fails++; $display("FAIL sw_access: got rd=%0d wr=%0d err=%b want 0 1 0", nrd, nwr, err); end
    endtask

    task automatic test_sb_lanes;
        logic [31:0] addrs [4] = '{32'h21, 32'h22, 32'h23, 32'h20};
        logic [31:0] exps  [4] = '{32'h1122AB44, 32'h11AB3344, 32'hAB223344, 32'h112233AB};
        int lat, nrd, nwr; logic err, ov, bs, bg; logic [31:0] wa, wd;
        for (int i = 0; i < 4; i++) begin
            do_op(2'd0, addrs[i], 32'hFFFFFFAB, 32'h11223344, 0, 0, 1'b0, lat, err, wa, wd, nrd, nwr, ov, bs, bg);
            tests++;
            if (wd !== exps[i] || wa !== 32'h20 || lat !== 4) begin
                fails++;
                $display("FAIL sb_lane%0d: got data=%h addr=%h lat=%0d want data=%h addr=20 lat=4",
                         i, wd, wa, lat, exps[i]);
            end
        end
    endtask

    task automatic test_sh;
        int lat, nrd, nwr; logic err, ov, bs, bg; logic [31:0] wa, wd;
        do_op(2'd1, 32'h32, 32'h0000BEEF, 32'h11223344, 0, 0, 1'b0, lat, err, wa, wd, nrd, nwr, ov, bs, bg);
        tests++; if (wd !== 32'hBEEF3344 || wa !== 32'h30) begin
            fails++; $display("FAIL sh_upper: got data=%h addr=%h want beef3344 at 30", wd, wa); end
        do_op(2'd1, 32'h30, 32'h0000BEEF, 32'h11223344, 0, 0, 1'b0, lat, err, wa, wd, nrd, nwr, ov, bs, bg);
        tests++; if (wd !== 32'h1122BEEF || lat !== 4) begin
            fails++; $display("FAIL sh_lower: got data=%h lat=%0d want 1122beef lat=4", wd, lat); end
    endtask

    task automatic test_errors;
        logic [1:0]  szs [3] = '{2'd1, 2'd2, 2'd3};
        logic [31:0] ads [3] = '{32'h41, 32'h42, 32'h40};
        int lat, nrd, nwr; logic err, ov, bs, bg; logic [31:0] wa, wd;
        for (int i = 0; i < 3; i++) begin
            do_op(szs[i], ads[i], 32'h12345678, 32'h0, 0, 0, 1'b0, lat, err, wa, wd, nrd, nwr, ov, bs, bg);
            tests++;
            if (lat !== 1 || err !== 1'b1 || nrd !== 0 || nwr !== 0) begin
                fails++;
                $display("FAIL err_case%0d: got lat=%0d err=%b rd=%0d wr=%0d want 1 1 0 0", i, lat, err, nrd, nwr);
            end
        end
    endtask

    task automatic test_wait_states;
        int lat, nrd, nwr; logic err, ov, bs, bg; logic [31:0] wa, wd;
        do_op(2'd0, 32'h51, 32'h000000C3, 32'hA5A5A5A5, 3, 2, 1'b1, lat, err, wa, wd, nrd, nwr, ov, bs, bg);
        tests++; if (lat !== 9) begin fails++; $display("FAIL wait_latency: got %0d want 9", lat); end
        tests++; if (nrd !== 4 || nwr !== 3) begin
            fails++; $display("FAIL wait_hold: got rd=%0d wr=%0d want 4 3", nrd, nwr); end
        tests++; if (wd !== 32'hA5A5C3A5 || wa !== 32'h50 || ov !== 1'b0 || bg !== 1'b0) begin
            fails++; $display("FAIL wait_data: got data=%h addr=%h overlap=%b busy_gap=%b want a5a5c3a5 50 0 0",
                              wd, wa, ov, bg); end
        // The ignored start must not have spawned a second operation.
        @(negedge clk);
        @(negedge clk);
        tests++; if (bus.busy !== 1'b0 || bus.mem_rd !== 1'b0 || bus.mem_wr !== 1'b0) begin
            fails++; $display("FAIL wait_ignored_start: got busy=%b rd=%b wr=%b want 0 0 0",
                              bus.busy, bus.mem_rd, bus.mem_wr); end
    endtask

    task automatic test_back_to_back;
        int lat, nrd, nwr; logic err, ov, bs, bg; logic [31:0] wa, wd;
        do_op(2'd2, 32'h60, 32'h01020304, 32'h0, 0, 0, 1'b0, lat, err, wa, wd, nrd, nwr, ov, bs, bg);
        do_op(2'd0, 32'h62, 32'h00000077, 32'h01020304, 0, 0, 1'b0, lat, err, wa, wd, nrd, nwr, ov, bs, bg);
        tests++; if (bs !== 1'b0 || lat !== 4 || wd !== 32'h01770304) begin
            fails++; $display("FAIL b2b: got busy_at_start=%b lat=%0d data=%h want 0 4 01770304", bs, lat, wd); end
    endtask

    task automatic test_reset_mid_write;
        int lat, nrd, nwr; logic err, ov, bs, bg; logic [31:0] wa, wd;
        logic seen_wr;
        @(negedge clk);
        bus.start = 1'b1; bus.size = 2'd0; bus.addr = 32'h71; bus.wdata = 32'h99;
        @(negedge clk);
        bus.start = 1'b0;
        seen_wr = 1'b0;
        for (int n = 0; n < 20; n++) begin
            bus.mem_ready = bus.mem_rd;
            bus.mem_rdata = 32'hCAFEF00D;
            if (bus.mem_wr) begin seen_wr = 1'b1; bus.mem_ready = 1'b0; break; end
            @(negedge clk);
        end
        tests++; if (seen_wr !== 1'b1) begin fails++; $display("FAIL rst_reach_write: got %b want 1", seen_wr); end
        #2 reset = 1'b0;
        #1;
        tests++;
        if ({bus.busy, bus.done, bus.misalign_err, bus.mem_rd, bus.mem_wr, bus.mem_addr, bus.mem_wdata} !== 69'd0) begin
            fails++;
            $display("FAIL rst_async: got busy=%b wr=%b addr=%h wdata=%h want all 0",
                     bus.busy, bus.mem_wr, bus.mem_addr, bus.mem_wdata);
        end
        @(negedge clk);
        reset = 1'b1;
        do_op(2'd0, 32'h73, 32'h00000042, 32'h10203040, 0, 0, 1'b0, lat, err, wa, wd, nrd, nwr, ov, bs, bg);
        tests++; if (lat !== 4 || wd !== 32'h42203040 || wa !== 32'h70 || nwr !== 1) begin
            fails++; $display("FAIL rst_fresh: got lat=%0d data=%h addr=%h wr=%0d want 4 42203040 70 1",
                              lat, wd, wa, nwr); end
    endtask

    task automatic test_random;
        int lat, nrd, nwr; logic err, ov, bs, bg; logic [31:0] wa, wd;
        logic [1:0] sz; logic [31:0] ad, wv, mw; int rdw, wrw;
        logic e;
        for (int i = 0; i < 40; i++) begin
            sz = 2'($urandom); ad = $urandom; wv = $urandom; mw = $urandom;
            rdw = int'($urandom_range(0, 3)); wrw = int'($urandom_range(0, 3));
            do_op(sz, ad, wv, mw, rdw, wrw, 1'($urandom), lat, err, wa, wd, nrd, nwr, ov, bs, bg);
            e = model_err(sz, ad);
            tests++;
            if (lat !== model_lat(sz, ad, rdw, wrw) || err !== e || ov !== 1'b0) begin
                fails++;
                $display("FAIL rnd%0d_ctrl: sz=%0d addr=%h got lat=%0d err=%b ov=%b want lat=%0d err=%b ov=0",
                         i, sz, ad, lat, err, ov, model_lat(sz, ad, rdw, wrw), e);
            end
            tests++;
            if (!e && (wd !== model_word(sz, ad, wv, mw) || wa !== {ad[31:2], 2'b00})) begin
                fails++;
                $display("FAIL rnd%0d_data: sz=%0d addr=%h got %h@%h want %h@%h", i, sz, ad, wd, wa,
                         model_word(sz, ad, wv, mw), {ad[31:2], 2'b00});
            end
            tests++;
            if (nrd !== ((e || sz == 2'd2) ? 0 : rdw + 1) || nwr !== (e ? 0 : wrw + 1)) begin
                fails++;
                $display("FAIL rnd%0d_access: got rd=%0d wr=%0d", i, nrd, nwr);
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset;
        test_sw;
        test_sb_lanes;
        test_sh;
        test_errors;
        test_wait_states;
        test_back_to_back;
        test_reset_mid_write;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
